// File: rtl/uartlite_pkg.sv
// Shared register map, STAT/CTRL bit positions and response codes for the UART Lite loopback slave.
// No logic; constants only.
package uartlite_pkg;

  typedef enum logic [1:0] {
    REG_RX   = 2'd0,
    REG_TX   = 2'd1,
    REG_STAT = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_RST_TX  = 0;
  localparam int CTRL_RST_RX  = 1;
  localparam int CTRL_INTR_EN = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lite_fifo.sv
// Synchronous FIFO with flush; full/empty/count come from the registered occupancy.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored; flush beats push/pop.
module lite_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uartlite_loopback_slave.sv
// AXI4-Lite UART Lite register slave whose TX FIFO drains into its RX FIFO, one byte per BYTE_CYCLES.
// Latency: registered one-cycle ready pulses, response valid on the following cycle.
// Backpressure: no new write/read is accepted while its response is still pending.
module uartlite_loopback_slave
  import uartlite_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int              CW       = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(BYTE_CYCLES - 1);
  localparam int              FCW      = $clog2(DEPTH) + 1;

  logic           aw_rdy;
  logic           ar_rdy;
  logic           wr_fire;
  logic           rd_fire;
  reg_sel_e       wr_sel;
  reg_sel_e       rd_sel;

  logic           tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic           rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]     tx_head, rx_head;
  logic [FCW-1:0] tx_count, rx_count;

  logic           ctrl_wr;
  logic           stat_rd;
  logic           xfer;
  logic           ovr_set;
  logic           intr_en;
  logic           overrun;
  logic [CW-1:0]  lb_cnt;
  logic [7:0]     stat;
  logic [7:0]     rd_byte;
  logic           unused_bits;

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = aw_rdy;
  assign s_axi_arready = ar_rdy;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;

  assign wr_fire = aw_rdy && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = ar_rdy && s_axi_arvalid;
  assign wr_sel  = reg_sel_e'(s_axi_awaddr[3:2]);
  assign rd_sel  = reg_sel_e'(s_axi_araddr[3:2]);

  assign ctrl_wr  = wr_fire && (wr_sel == REG_CTRL);
  assign tx_push  = wr_fire && (wr_sel == REG_TX) && s_axi_wstrb[0];
  assign tx_flush = ctrl_wr && s_axi_wdata[CTRL_RST_TX];
  assign rx_flush = ctrl_wr && s_axi_wdata[CTRL_RST_RX];
  assign stat_rd  = rd_fire && (rd_sel == REG_STAT);
  assign rx_pop   = rd_fire && (rd_sel == REG_RX) && !rx_empty;

  // A TX flush cancels a transfer landing on the same edge; RX fullness uses the pre-edge count.
  assign xfer    = !tx_empty && (lb_cnt == CNT_LAST) && !tx_flush;
  assign tx_pop  = xfer;
  assign rx_push = xfer;
  assign ovr_set = xfer && rx_full;

  lite_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_dat (s_axi_wdata[7:0]),
    .pop      (tx_pop),
    .flush    (tx_flush),
    .pop_dat  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  lite_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_dat (tx_head),
    .pop      (rx_pop),
    .flush    (rx_flush),
    .pop_dat  (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  always_comb begin
    stat                = '0;
    stat[STAT_RX_VALID] = !rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_INTR_EN]  = intr_en;
    stat[STAT_OVERRUN]  = overrun;
  end

  always_comb begin
    rd_byte = '0;
    case (rd_sel)
      REG_RX:   rd_byte = rx_empty ? 8'h00 : rx_head;
      REG_STAT: rd_byte = stat;
      default:  rd_byte = '0;
    endcase
  end

  // Write channel: ready pulses only when both AW and W are present and no response is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_rdy       <= 1'b0;
      s_axi_bvalid <= 1'b0;
    end else begin
      aw_rdy <= !aw_rdy && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      if (wr_fire)           s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_rdy       <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      ar_rdy <= !ar_rdy && s_axi_arvalid && !s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= {24'h0, rd_byte};
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr_en <= 1'b0;
      overrun <= 1'b0;
      lb_cnt  <= '0;
    end else begin
      if (ctrl_wr) intr_en <= s_axi_wdata[CTRL_INTR_EN];
      if (ovr_set)      overrun <= 1'b1;
      else if (stat_rd) overrun <= 1'b0;
      if (tx_flush || tx_empty || xfer) lb_cnt <= '0;
      else                              lb_cnt <= lb_cnt + CW'(1);
    end
  end

  assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_araddr[31:4],
                         s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wdata[7:5],
                         s_axi_wdata[3:2], s_axi_wstrb[3:1], tx_count, rx_count};

endmodule

// File: tb/tb_uartlite_loopback_slave.sv
// Directed bench: dut 0 uses BYTE_CYCLES=4, dut 1 uses BYTE_CYCLES=1000; both DEPTH=16.
module tb_uartlite_loopback_slave;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][31:0] awaddr, wdata, araddr, rdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]       arvalid, arready, rvalid, rready;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  uartlite_loopback_slave #(.DEPTH(16), .BYTE_CYCLES(4)) dut_fast (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr[0]), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
    .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
    .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
    .s_axi_araddr(araddr[0]), .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
    .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0])
  );

  uartlite_loopback_slave #(.DEPTH(16), .BYTE_CYCLES(1000)) dut_slow (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr[1]), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
    .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
    .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
    .s_axi_araddr(araddr[1]), .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
    .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the accepting edge.
  task automatic wr(input int d, input logic [3:0] addr, input logic [7:0] data,
                    input logic [3:0] strb, input string tag);
    int n;
    awaddr[d] = {28'h0, addr};
    wdata[d]  = {24'h0, data};
    wstrb[d]  = strb;
    awvalid[d] = 1'b1;
    wvalid[d]  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!awready[d] && n < 50);
    chk({tag, "_awready"}, 32'(awready[d] & wready[d]), 32'd1);
    @(posedge clk); #1;
    awvalid[d] = 1'b0;
    wvalid[d]  = 1'b0;
    chk({tag, "_bvalid"}, 32'(bvalid[d]), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp[d]), 32'd0);
  endtask

  // arready is raised by the first edge after entry; the handshake is on the edge after that.
  task automatic rd(input int d, input logic [3:0] addr, input logic [31:0] exp, input string tag);
    int n;
    araddr[d]  = {28'h0, addr};
    arvalid[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready[d] && n < 50);
    chk({tag, "_arready"}, 32'(arready[d]), 32'd1);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid[d]), 32'd1);
    chk({tag, "_rresp"}, 32'(rresp[d]), 32'd0);
    chk(tag, rdata[d], exp);
    rready[d] = 1'b1;
    @(posedge clk); #1;
    rready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = 2'b11;
    rready = 2'b00;
    #2;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata[0] | rdata[1], 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // STAT after reset, arready pulse width, rvalid held under rready=0
    araddr[0]  = 32'h8;
    arvalid[0] = 1'b1;
    @(posedge clk); #1;
    chk("t1_arready_up", 32'(arready[0]), 32'd1);
    @(posedge clk); #1;
    arvalid[0] = 1'b0;
    chk("t1_arready_one_cycle", 32'(arready[0]), 32'd0);
    chk("t1_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t1_stat", rdata[0], 32'h04);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t1_rvalid_hold", 32'(rvalid[0]), 32'd1);
      chk("t1_rdata_hold", rdata[0], 32'h04);
    end
    rready[0] = 1'b1;
    @(posedge clk); #1;
    rready[0] = 1'b0;
    chk("t1_rvalid_drop", 32'(rvalid[0]), 32'd0);

    // Loopback latency, BYTE_CYCLES=4: push at edge N, RX holds it after edge N+4
    wr(0, 4'h4, 8'h41, 4'h1, "t2_wr41");
    repeat (2) @(posedge clk); #1;
    rd(0, 4'h8, 32'h00, "t2_stat_n4");
    rd(0, 4'h0, 32'h41, "t2_rx41");
    rd(0, 4'h8, 32'h04, "t2_stat_after");
    wr(0, 4'h4, 8'h42, 4'h1, "t2_wr42");
    repeat (3) @(posedge clk); #1;
    rd(0, 4'h8, 32'h05, "t2_stat_n5");
    rd(0, 4'h0, 32'h42, "t2_rx42");
    rd(0, 4'h8, 32'h04, "t2_stat_empty");

    // Dropped/ignored accesses
    wr(0, 4'h4, 8'h99, 4'b1110, "t3_nostrb");
    wr(0, 4'h8, 8'hFF, 4'h1, "t3_wr_stat");
    repeat (10) @(posedge clk); #1;
    rd(0, 4'h8, 32'h04, "t3_stat");
    rd(0, 4'h0, 32'h00, "t3_rx_empty");
    rd(0, 4'h4, 32'h00, "t3_rd_tx");
    rd(0, 4'hC, 32'h00, "t3_rd_ctrl");

    // RX overrun: 17 bytes into a 16-deep RX
    for (int i = 0; i < 17; i++) wr(0, 4'h4, 8'(8'h50 + i), 4'h1, "t4_wr");
    repeat (100) @(posedge clk); #1;
    rd(0, 4'h8, 32'h27, "t4_stat_ovr");
    rd(0, 4'h8, 32'h07, "t4_stat_ovr_clr");
    for (int i = 0; i < 16; i++) rd(0, 4'h0, 32'(8'h50 + i), "t4_rx");
    rd(0, 4'h8, 32'h04, "t4_stat_drained");

    // CTRL flush of both FIFOs plus intr_en
    wr(0, 4'h4, 8'h71, 4'h1, "t5_wr71");
    repeat (10) @(posedge clk); #1;
    wr(0, 4'h4, 8'h72, 4'h1, "t5_wr72");
    wr(0, 4'h4, 8'h73, 4'h1, "t5_wr73");
    wr(0, 4'hC, 8'h13, 4'h1, "t5_ctrl");
    rd(0, 4'h8, 32'h14, "t5_stat");
    repeat (20) @(posedge clk); #1;
    rd(0, 4'h8, 32'h14, "t5_stat_later");
    rd(0, 4'h0, 32'h00, "t5_rx_empty");
    wr(0, 4'hC, 8'h00, 4'h1, "t5_ctrl_clr");
    rd(0, 4'h8, 32'h04, "t5_stat_clr");

    // TX full with BYTE_CYCLES=1000: 17th byte dropped
    for (int i = 0; i < 17; i++) wr(1, 4'h4, 8'(8'h10 + i), 4'h1, "t6_wr");
    rd(1, 4'h8, 32'h08, "t6_stat_txfull");
    repeat (16100) @(posedge clk); #1;
    rd(1, 4'h8, 32'h07, "t6_stat_rxfull");
    for (int i = 0; i < 16; i++) rd(1, 4'h0, 32'(8'h10 + i), "t6_rx");
    rd(1, 4'h8, 32'h04, "t6_stat_drained");
    rd(1, 4'h0, 32'h00, "t6_rx_empty");

    // Asynchronous reset with a pending write response and the counter mid-count
    bready[1] = 1'b0;
    wr(1, 4'h4, 8'hAB, 4'h1, "t7_wr");
    repeat (5) @(posedge clk); #1;
    chk("t7_bvalid_held", 32'(bvalid[1]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t7_bvalid_async", 32'(bvalid[1]), 32'd0);
    chk("t7_awready_async", 32'(awready[1]), 32'd0);
    @(negedge clk) rst = 1'b1;
    bready[1] = 1'b1;
    @(posedge clk); #1;
    rd(1, 4'h8, 32'h04, "t7_stat");
    repeat (1100) @(posedge clk); #1;
    rd(1, 4'h8, 32'h04, "t7_stat_later");
    rd(1, 4'h0, 32'h00, "t7_rx_empty");
    rd(0, 4'h8, 32'h04, "t7_fast_stat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
